// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction encoding, the
// opposite-direction helper and the IR remote command codes.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam logic [7:0] IR_CODE_UP    = 8'h18;
   localparam logic [7:0] IR_CODE_DOWN  = 8'h52;
   localparam logic [7:0] IR_CODE_LEFT  = 8'h08;
   localparam logic [7:0] IR_CODE_RIGHT = 8'h5A;
   localparam logic [7:0] IR_CODE_OK    = 8'h1C;

   // Up/down and left/right differ only in bit 0.
   function automatic logic [1:0] dir_opposite(input logic [1:0] d);
      return d ^ 2'b01;
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// Generic synchronous FIFO with a registered show-ahead head and level count.
// A push while full is accepted only when a pop happens in the same cycle.
module dir_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LvlFull = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q, rd_next;
   logic [AW:0]      level_q;
   logic [WIDTH-1:0] head_q;
   logic             pop_ok, push_ok;

   // Handshake qualification: pop needs data, push needs room or a same-cycle pop.
   always_comb begin
      pop_ok  = pop && (level_q != '0);
      push_ok = push && ((level_q != LvlFull) || pop_ok);
      rd_next = rd_ptr_q + 1'b1;
   end

   // Storage array; contents beyond the pointers are don't-care, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers, level and head register.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_next;
         unique case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         // New data becomes head when the queue is (or is about to be) empty.
         if (push_ok && ((level_q == '0) || (pop_ok && (level_q == (AW+1)'(1))))) begin
            head_q <= wdata;
         end else if (pop_ok && (level_q > (AW+1)'(1))) begin
            head_q <= mem_q[rd_next];
         end
      end
   end

   assign rdata = head_q;
   assign valid = (level_q != '0);
   assign full  = (level_q == LvlFull);
   assign level = level_q;

endmodule

// File: rtl/dir_cmd_queue.sv
// Direction command queue in front of game_logic: merges key flags and IR
// frames, drops reversals/duplicates, and buffers legal turns in a FIFO.
// Optional macro DIR_CMD_IR_REPEAT_EN: IR repeat frames re-present the last
// IR direction as a candidate.
module dir_cmd_queue
   import snake_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [7:0]  IR_UP    = IR_CODE_UP,
   parameter logic [7:0]  IR_DOWN  = IR_CODE_DOWN,
   parameter logic [7:0]  IR_LEFT  = IR_CODE_LEFT,
   parameter logic [7:0]  IR_RIGHT = IR_CODE_RIGHT,
   parameter logic [7:0]  IR_OK    = IR_CODE_OK,
   parameter logic [1:0]  INIT_DIR = 2'd3
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   kf_up,
   input  logic                   kf_down,
   input  logic                   kf_left,
   input  logic                   kf_right,
   input  logic                   ir_data_en,
   input  logic [7:0]             ir_data,
   input  logic                   ir_repeat_en,
   input  logic                   cmd_ready,
   output logic                   cmd_valid,
   output logic [1:0]             cmd_dir,
   output logic                   paused,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] level
);

   logic       paused_q, paused_d;
   logic       overflow_q, overflow_d;
   logic [1:0] last_dir_q, last_dir_d;

   logic       ir_dir_hit;
   logic [1:0] ir_dir;
   logic       cand_valid;
   logic [1:0] cand_dir;
   logic       toggle;
   logic       push_req;
   logic       pop;
   logic       fifo_full;

   // IR byte decode into a direction.
   always_comb begin
      ir_dir_hit = 1'b0;
      ir_dir     = DIR_UP;
      if (ir_data_en) begin
         if (ir_data == IR_UP) begin
            ir_dir_hit = 1'b1;
            ir_dir     = DIR_UP;
         end else if (ir_data == IR_DOWN) begin
            ir_dir_hit = 1'b1;
            ir_dir     = DIR_DOWN;
         end else if (ir_data == IR_LEFT) begin
            ir_dir_hit = 1'b1;
            ir_dir     = DIR_LEFT;
         end else if (ir_data == IR_RIGHT) begin
            ir_dir_hit = 1'b1;
            ir_dir     = DIR_RIGHT;
         end
      end
   end

`ifdef DIR_CMD_IR_REPEAT_EN
   logic [1:0] last_ir_dir_q;
   logic       last_ir_vld_q;

   // Remember the last IR direction so repeat frames can re-present it.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         last_ir_dir_q <= 2'd0;
         last_ir_vld_q <= 1'b0;
      end else if (ir_dir_hit) begin
         last_ir_dir_q <= ir_dir;
         last_ir_vld_q <= 1'b1;
      end
   end
`else
   logic unused_ir_repeat;
   assign unused_ir_repeat = ir_repeat_en;
`endif

   // Source select: keys (up > down > left > right) beat IR; OK toggles pause
   // regardless of which source wins.
   always_comb begin
      cand_valid = 1'b0;
      cand_dir   = DIR_UP;
      if (kf_up) begin
         cand_valid = 1'b1;
         cand_dir   = DIR_UP;
      end else if (kf_down) begin
         cand_valid = 1'b1;
         cand_dir   = DIR_DOWN;
      end else if (kf_left) begin
         cand_valid = 1'b1;
         cand_dir   = DIR_LEFT;
      end else if (kf_right) begin
         cand_valid = 1'b1;
         cand_dir   = DIR_RIGHT;
      end else if (ir_dir_hit) begin
         cand_valid = 1'b1;
         cand_dir   = ir_dir;
`ifdef DIR_CMD_IR_REPEAT_EN
      end else if (ir_repeat_en && last_ir_vld_q) begin
         cand_valid = 1'b1;
         cand_dir   = last_ir_dir_q;
`endif
      end
      toggle = ir_data_en && (ir_data == IR_OK);
   end

   // Filter and state next-values; a toggle cycle flushes, so it never pushes.
   always_comb begin
      paused_d   = paused_q;
      overflow_d = overflow_q;
      last_dir_d = last_dir_q;
      push_req   = cand_valid && !paused_q && !toggle
                   && (cand_dir != last_dir_q)
                   && (cand_dir != dir_opposite(last_dir_q));
      pop        = cmd_valid && cmd_ready && !toggle;
      if (toggle) paused_d = !paused_q;
      if (push_req) begin
         if (fifo_full && !pop) begin
            overflow_d = 1'b1;
         end else begin
            last_dir_d = cand_dir;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         paused_q   <= 1'b0;
         overflow_q <= 1'b0;
         last_dir_q <= INIT_DIR;
      end else begin
         paused_q   <= paused_d;
         overflow_q <= overflow_d;
         last_dir_q <= last_dir_d;
      end
   end

   dir_fifo #(
      .WIDTH (2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .flush (toggle),
      .push  (push_req),
      .wdata (cand_dir),
      .pop   (pop),
      .rdata (cmd_dir),
      .valid (cmd_valid),
      .full  (fifo_full),
      .level (level)
   );

   assign paused   = paused_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Directed self-checking bench for dir_cmd_queue (default build, DEPTH=4).
module tb_dir_cmd_queue;

   localparam logic [3:0] K_NONE  = 4'b0000;
   localparam logic [3:0] K_UP    = 4'b1000;
   localparam logic [3:0] K_DOWN  = 4'b0100;
   localparam logic [3:0] K_LEFT  = 4'b0010;
   localparam logic [3:0] K_RIGHT = 4'b0001;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       kf_up = 1'b0, kf_down = 1'b0, kf_left = 1'b0, kf_right = 1'b0;
   logic       ir_data_en = 1'b0;
   logic [7:0] ir_data = 8'h00;
   logic       ir_repeat_en = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_dir;
   logic       paused;
   logic       overflow;
   logic [2:0] level;

   int n_checks = 0;
   int n_errors = 0;

   dir_cmd_queue u_dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .kf_up        (kf_up),
      .kf_down      (kf_down),
      .kf_left      (kf_left),
      .kf_right     (kf_right),
      .ir_data_en   (ir_data_en),
      .ir_data      (ir_data),
      .ir_repeat_en (ir_repeat_en),
      .cmd_ready    (cmd_ready),
      .cmd_valid    (cmd_valid),
      .cmd_dir      (cmd_dir),
      .paused       (paused),
      .overflow     (overflow),
      .level        (level)
   );

   always #20 sys_clk = ~sys_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then return to idle; sampling is 1 time unit after the edge.
   task automatic step(input logic [3:0] keys, input logic ir_en, input logic [7:0] code,
                       input logic rdy);
      {kf_up, kf_down, kf_left, kf_right} = keys;
      ir_data_en = ir_en;
      ir_data    = code;
      cmd_ready  = rdy;
      @(posedge sys_clk);
      #1;
      {kf_up, kf_down, kf_left, kf_right} = K_NONE;
      ir_data_en = 1'b0;
      ir_data    = 8'h00;
      cmd_ready  = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_valid", int'(cmd_valid), 0);
      check("rst_dir", int'(cmd_dir), 0);
      check("rst_paused", int'(paused), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_level", int'(level), 0);

      // First command onto an empty queue, one cycle latency
      repeat (9) step(K_NONE, 1'b0, 8'h00, 1'b0);
      step(K_UP, 1'b0, 8'h00, 1'b0);
      check("up_valid", int'(cmd_valid), 1);
      check("up_dir", int'(cmd_dir), 0);
      check("up_level", int'(level), 1);

      // Reversal and duplicate against INIT_DIR=right; IR decode
      do_reset();
      step(K_LEFT, 1'b0, 8'h00, 1'b0);
      check("rev_valid", int'(cmd_valid), 0);
      step(K_RIGHT, 1'b0, 8'h00, 1'b0);
      check("dup_valid", int'(cmd_valid), 0);
      step(K_NONE, 1'b1, 8'h77, 1'b0);
      check("ir_unknown_level", int'(level), 0);
      step(K_NONE, 1'b1, 8'h52, 1'b0);
      check("ir_down_level", int'(level), 1);
      check("ir_down_dir", int'(cmd_dir), 1);

      // Key priority and chained validation against last enqueued direction
      do_reset();
      step(K_UP | K_LEFT, 1'b0, 8'h00, 1'b0);
      check("prio_level", int'(level), 1);
      check("prio_dir", int'(cmd_dir), 0);
      step(K_LEFT, 1'b0, 8'h00, 1'b0);
      step(K_NONE, 1'b1, 8'h5A, 1'b0);
      check("ir_rev_level", int'(level), 2);
      step(K_DOWN, 1'b0, 8'h00, 1'b0);
      check("chain_level", int'(level), 3);
      check("chain_head0", int'(cmd_dir), 0);
      step(K_NONE, 1'b0, 8'h00, 1'b1);
      check("chain_head1", int'(cmd_dir), 2);
      check("chain_level2", int'(level), 2);
      step(K_NONE, 1'b0, 8'h00, 1'b1);
      check("chain_head2", int'(cmd_dir), 1);
      step(K_NONE, 1'b0, 8'h00, 1'b1);
      check("chain_empty", int'(cmd_valid), 0);
      step(K_NONE, 1'b0, 8'h00, 1'b1);
      check("pop_empty_level", int'(level), 0);

      // Full queue: overflow on blocked push, push+pop when full accepted
      do_reset();
      step(K_UP, 1'b0, 8'h00, 1'b0);
      step(K_LEFT, 1'b0, 8'h00, 1'b0);
      step(K_DOWN, 1'b0, 8'h00, 1'b0);
      step(K_RIGHT, 1'b0, 8'h00, 1'b0);
      check("full_level", int'(level), 4);
      check("full_ovf0", int'(overflow), 0);
      step(K_UP, 1'b0, 8'h00, 1'b0);
      check("ovf_set", int'(overflow), 1);
      check("ovf_level", int'(level), 4);
      check("ovf_head", int'(cmd_dir), 0);
      step(K_UP, 1'b0, 8'h00, 1'b1);
      check("pushpop_level", int'(level), 4);
      check("pushpop_head", int'(cmd_dir), 2);
      check("pushpop_ovf", int'(overflow), 1);

      // Pause toggle flushes, blocks pushes, keeps overflow and last_dir (up)
      step(K_NONE, 1'b1, 8'h1C, 1'b0);
      check("pause_on", int'(paused), 1);
      check("pause_flush", int'(level), 0);
      check("pause_valid", int'(cmd_valid), 0);
      check("pause_ovf", int'(overflow), 1);
      step(K_DOWN, 1'b0, 8'h00, 1'b0);
      check("paused_drop", int'(level), 0);
      step(K_NONE, 1'b1, 8'h1C, 1'b0);
      check("pause_off", int'(paused), 0);
      step(K_DOWN, 1'b0, 8'h00, 1'b0);
      check("lastdir_kept_rev", int'(level), 0);
      step(K_LEFT, 1'b0, 8'h00, 1'b0);
      check("unpause_push", int'(level), 1);
      check("unpause_dir", int'(cmd_dir), 2);
      step(K_DOWN, 1'b0, 8'h00, 1'b0);
      step(K_RIGHT, 1'b0, 8'h00, 1'b0);
      check("pre_rst_level", int'(level), 3);

      // Reset mid-operation with level=3 and overflow=1
      do_reset();
      check("mid_rst_valid", int'(cmd_valid), 0);
      check("mid_rst_level", int'(level), 0);
      check("mid_rst_ovf", int'(overflow), 0);
      check("mid_rst_dir", int'(cmd_dir), 0);
      step(K_NONE, 1'b1, 8'h1C, 1'b0);
      check("rst_pause_pre", int'(paused), 1);
      do_reset();
      check("mid_rst_paused", int'(paused), 0);
      step(K_LEFT, 1'b0, 8'h00, 1'b0);
      check("post_rst_rev", int'(cmd_valid), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
